// File: rtl/intc.sv
// Fixed-priority interrupt controller: edge/level sources, pending latch,
// a three-state request/claim/complete handshake and a small register window.
module intc #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned ID_W      = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq_i,
    input  logic               reg_we_i,
    input  logic               reg_re_i,
    input  logic [31:0]        reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic [31:0] OFF_ENABLE   = 32'h00;
    localparam logic [31:0] OFF_PENDING  = 32'h04;
    localparam logic [31:0] OFF_MODE     = 32'h08;
    localparam logic [31:0] OFF_CLAIM    = 32'h0C;
    localparam logic [31:0] OFF_COMPLETE = 32'h10;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [NUM_SRC-1:0]   mode_q, mode_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   src_q;
    logic [31:0]          rdata_q, rdata_d;

    logic [31:0]          offset;
    logic                 in_window;
    logic                 wr_enable, wr_pending, wr_mode, wr_complete;
    logic [NUM_SRC-1:0]   active;
    logic [NUM_SRC-1:0]   sel_vec;
    logic [NUM_SRC-1:0]   claim_clr;
    logic [NUM_SRC-1:0]   w1c_clr;
    logic [NUM_SRC-1:0]   edge_set;
    logic [NUM_SRC-1:0]   edge_pend;
    logic [ID_W-1:0]      winner_id;
    logic                 any_active;
    logic                 sel_active;

    // Address decode: word-aligned offsets 0x00..0x10 above the base are mapped.
    always_comb begin
        offset      = reg_addr_i - BASE_ADDR;
        in_window   = (offset < 32'h14) && (offset[1:0] == 2'b00);
        wr_enable   = reg_we_i && in_window && (offset == OFF_ENABLE);
        wr_pending  = reg_we_i && in_window && (offset == OFF_PENDING);
        wr_mode     = reg_we_i && in_window && (offset == OFF_MODE);
        wr_complete = reg_we_i && in_window && (offset == OFF_COMPLETE);
    end

    // Fixed-priority arbitration over enabled pending bits; lowest index wins.
    always_comb begin
        active     = pending_q & enable_q;
        any_active = |active;
        winner_id  = '0;
        sel_vec    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (active[k]) winner_id = ID_W'(k + 1);
            sel_vec[k] = (id_q == ID_W'(k + 1));
        end
        sel_active = |(sel_vec & active);
    end

    // Handshake FSM: latch winner, wait for ack, hold service until COMPLETE.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        claim_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                id_d = '0;
                if (any_active) begin
                    state_d = ST_REQ;
                    id_d    = winner_id;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d   = ST_SERVE;
                    claim_clr = sel_vec;
                end else if (!sel_active) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                end
            end
            ST_SERVE: begin
                if (wr_complete) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
            end
        endcase
    end

    // Pending/config next state; a new edge beats W1C or claim in the same cycle.
    always_comb begin
        enable_d  = wr_enable ? reg_wdata_i[NUM_SRC-1:0] : enable_q;
        mode_d    = wr_mode   ? reg_wdata_i[NUM_SRC-1:0] : mode_q;
        w1c_clr   = wr_pending ? reg_wdata_i[NUM_SRC-1:0] : '0;
        edge_set  = src_irq_i & ~src_q & mode_q;
        edge_pend = (pending_q & ~(w1c_clr | claim_clr)) | edge_set;
        pending_d = (mode_q & edge_pend) | (~mode_q & src_irq_i);
    end

    // Registered read mux; zero when not reading or outside the window.
    always_comb begin
        rdata_d = '0;
        if (reg_re_i && in_window) begin
            unique case (offset)
                OFF_ENABLE:  rdata_d = 32'(enable_q);
                OFF_PENDING: rdata_d = 32'(pending_q);
                OFF_MODE:    rdata_d = 32'(mode_q);
                OFF_CLAIM:   rdata_d = (state_q == ST_SERVE) ? 32'(id_q) : 32'd0;
                default:     rdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            src_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            src_q     <= src_irq_i;
            rdata_q   <= rdata_d;
        end
    end

    assign irq_req_o   = (state_q == ST_REQ);
    assign irq_id_o    = id_q;
    assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: handshake, priority, enable gating, level drop,
// W1C/edge collision and reset during service.
module tb_intc;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_EN = BASE + 32'h00;
    localparam logic [31:0] A_PD = BASE + 32'h04;
    localparam logic [31:0] A_MD = BASE + 32'h08;
    localparam logic [31:0] A_CL = BASE + 32'h0C;
    localparam logic [31:0] A_CP = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src_irq_i;
    logic        reg_we_i, reg_re_i;
    logic [31:0] reg_addr_i, reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_val;

    intc #(.NUM_SRC(4), .ID_W(5), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_irq_i   (src_irq_i),
        .reg_we_i    (reg_we_i),
        .reg_re_i    (reg_re_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .irq_req_o   (irq_req_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        tick();
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        reg_re_i   = 1'b1;
        reg_addr_i = addr;
        tick();
        reg_re_i   = 1'b0;
        reg_addr_i = '0;
        data       = reg_rdata_o;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; src_irq_i = '0; reg_we_i = 1'b0; reg_re_i = 1'b0;
        reg_addr_i = '0; reg_wdata_i = '0; irq_ack_i = 1'b0;
        #1;
        repeat (3) tick();
        check("rst_req", 32'(irq_req_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        check("rst_rdata", reg_rdata_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Edge on src[2]: request ID 3 two edges later, claim clears pending.
        wr(A_MD, 32'hF);
        wr(A_EN, 32'hF);
        rd(A_EN, rd_val);
        check("en_readback", rd_val, 32'hF);
        src_irq_i = 4'b0100;
        tick();
        src_irq_i = '0;
        check("edge2_lat1_req", 32'(irq_req_o), 32'd0);
        tick();
        check("edge2_req", 32'(irq_req_o), 32'd1);
        check("edge2_id", 32'(irq_id_o), 32'd3);
        ack();
        check("edge2_ack_req", 32'(irq_req_o), 32'd0);
        check("edge2_serve_id", 32'(irq_id_o), 32'd3);
        rd(A_CL, rd_val);
        check("edge2_claim", rd_val, 32'd3);
        rd(A_PD, rd_val);
        check("edge2_pend", rd_val, 32'd0);
        tick();
        check("serve_no_req", 32'(irq_req_o), 32'd0);
        wr(A_CP, 32'h0);
        tick();
        check("after_cp_req", 32'(irq_req_o), 32'd0);

        // Simultaneous edges on src[1] and src[3]: ID 2 then ID 4.
        src_irq_i = 4'b1010;
        tick();
        src_irq_i = '0;
        tick();
        check("dual_first_id", 32'(irq_id_o), 32'd2);
        check("dual_first_req", 32'(irq_req_o), 32'd1);
        ack();
        wr(A_CP, 32'h0);
        check("dual_cp_req", 32'(irq_req_o), 32'd0);
        tick();
        check("dual_second_req", 32'(irq_req_o), 32'd1);
        check("dual_second_id", 32'(irq_id_o), 32'd4);
        ack();
        wr(A_CP, 32'h0);

        // Disabled source latches pending but does not request.
        wr(A_EN, 32'h0);
        src_irq_i = 4'b0001;
        tick();
        src_irq_i = '0;
        tick();
        tick();
        check("dis_no_req", 32'(irq_req_o), 32'd0);
        rd(A_PD, rd_val);
        check("dis_pend", rd_val, 32'd1);
        wr(A_EN, 32'h1);
        tick();
        check("en_req", 32'(irq_req_o), 32'd1);
        check("en_id", 32'(irq_id_o), 32'd1);
        ack();
        wr(A_CP, 32'h0);

        // Level source dropping before ack withdraws the request.
        wr(A_MD, 32'h0);
        src_irq_i = 4'b0001;
        tick();
        tick();
        check("lvl_req", 32'(irq_req_o), 32'd1);
        src_irq_i = '0;
        tick();
        check("lvl_hold_req", 32'(irq_req_o), 32'd1);
        tick();
        check("lvl_drop_req", 32'(irq_req_o), 32'd0);
        rd(A_PD, rd_val);
        check("lvl_pend", rd_val, 32'd0);
        check("lvl_idle_req", 32'(irq_req_o), 32'd0);

        // W1C colliding with a new edge on src[2]: set wins.
        wr(A_MD, 32'hF);
        wr(A_EN, 32'h0);
        src_irq_i = 4'b0100;
        tick();
        src_irq_i = '0;
        tick();
        src_irq_i   = 4'b0100;
        reg_we_i    = 1'b1;
        reg_addr_i  = A_PD;
        reg_wdata_i = 32'h4;
        tick();
        reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0; src_irq_i = '0;
        tick();
        rd(A_PD, rd_val);
        check("w1c_vs_edge", rd_val, 32'h4);
        wr(A_PD, 32'h4);
        rd(A_PD, rd_val);
        check("w1c_alone", rd_val, 32'h0);
        rd(BASE + 32'h40, rd_val);
        check("unmapped_rd", rd_val, 32'h0);
        wr(BASE - 32'h8, 32'hF);
        rd(A_EN, rd_val);
        check("outside_wr", rd_val, 32'h0);

        // Reset during SERVE clears everything; held source is level-only.
        wr(A_EN, 32'hF);
        src_irq_i = 4'b0010;
        tick();
        src_irq_i = '0;
        tick();
        check("pre_rst_id", 32'(irq_id_o), 32'd2);
        ack();
        src_irq_i = 4'b1000;
        rst_n = 1'b0;
        tick();
        check("rst_mid_req", 32'(irq_req_o), 32'd0);
        check("rst_mid_id", 32'(irq_id_o), 32'd0);
        check("rst_mid_rdata", reg_rdata_o, 32'd0);
        rst_n = 1'b1;
        tick();
        rd(A_CL, rd_val);
        check("rst_claim", rd_val, 32'd0);
        rd(A_MD, rd_val);
        check("rst_mode", rd_val, 32'd0);
        tick();
        tick();
        check("rst_no_req", 32'(irq_req_o), 32'd0);
        src_irq_i = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
